// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: active-low column scan, synchronized row sampling,
// frame-based press/release debounce and a 16-bit shift-in entry register.
module hex_keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 4096,
    parameter int unsigned DEBOUNCE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] entry
);

    localparam int unsigned   CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [7:0]    DB_LAST   = 8'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    row_s1_q, row_s2_q;
    logic [1:0]    hit_cnt_q, hit_cnt_d;
    logic [3:0]    hit_code_q, hit_code_d;
    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_held_q, key_held_d;
    logic [15:0]   entry_q, entry_d;

    logic       phase_end, frame_done;
    logic [3:0] pressed;
    logic [2:0] col_hits, tot3;
    logic [1:0] col_sat, frame_hits, hit_row;
    logic [3:0] frame_code;
    logic       accept, release_done;
    logic [7:0] cnt_inc;

    // Scan timing: column index and the one-hot-low drive advance together.
    always_comb begin
        phase_end  = (scan_cnt_q == SCAN_LAST);
        frame_done = phase_end && (col_idx_q == 2'd3);
        scan_cnt_d = phase_end ? '0 : scan_cnt_q + CW'(1);
        col_idx_d  = phase_end ? col_idx_q + 2'd1 : col_idx_q;
        col_d      = phase_end ? {col_q[2:0], col_q[3]} : col_q;
    end

    // Count pressed rows in the current column and locate the (single) hit.
    always_comb begin
        pressed  = ~row_s2_q;
        col_hits = '0;
        hit_row  = '0;
        for (int i = 0; i < 4; i++) begin
            if (pressed[i]) begin
                col_hits = col_hits + 3'd1;
                hit_row  = 2'(i);
            end
        end
        col_sat    = (col_hits >= 3'd2) ? 2'd2 : col_hits[1:0];
        tot3       = {1'b0, hit_cnt_q} + {1'b0, col_sat};
        frame_hits = (tot3 >= 3'd2) ? 2'd2 : tot3[1:0];
        frame_code = (hit_cnt_q != 2'd0) ? hit_code_q : {hit_row, col_idx_q};
        hit_cnt_d  = hit_cnt_q;
        hit_code_d = hit_code_q;
        if (phase_end) begin
            hit_cnt_d  = frame_done ? 2'd0 : frame_hits;
            hit_code_d = frame_code;
        end
    end

    // Debounce FSM: frame_hits is 0 (NONE), 1 (SINGLE) or 2 (MULTI, saturated).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        accept       = 1'b0;
        release_done = 1'b0;
        cnt_inc      = cnt_q + 8'd1;
        if (frame_done) begin
            unique case (state_q)
                S_IDLE: begin
                    if (frame_hits == 2'd1) begin
                        state_d = S_DEBOUNCE;
                        cand_d  = frame_code;
                        cnt_d   = 8'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (frame_hits == 2'd1 && frame_code == cand_q) begin
                        if (cnt_inc == DB_LAST) begin
                            accept  = 1'b1;
                            state_d = S_HELD;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (frame_hits == 2'd1) begin
                        cand_d = frame_code;
                        cnt_d  = 8'd1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end
                end
                S_HELD: begin
                    if (frame_hits == 2'd0) begin
                        state_d = S_RELEASE;
                        cnt_d   = 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (frame_hits == 2'd0) begin
                        if (cnt_inc == DB_LAST) begin
                            state_d      = S_IDLE;
                            cnt_d        = 8'd0;
                            release_done = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = S_HELD;
                        cnt_d   = 8'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // An accept and a clear in the same cycle leave only the new code.
    always_comb begin
        key_valid_d = accept;
        key_code_d  = accept ? cand_q : key_code_q;
        key_held_d  = accept ? 1'b1 : (release_done ? 1'b0 : key_held_q);
        if (accept)
            entry_d = clr ? {12'h000, cand_q} : {entry_q[11:0], cand_q};
        else
            entry_d = clr ? 16'h0000 : entry_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            row_s1_q    <= 4'b1111;
            row_s2_q    <= 4'b1111;
            hit_cnt_q   <= 2'd0;
            hit_code_q  <= 4'h0;
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            cand_q      <= 4'h0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
            entry_q     <= 16'h0000;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            row_s1_q    <= row;
            row_s2_q    <= row_s1_q;
            hit_cnt_q   <= hit_cnt_d;
            hit_code_q  <= hit_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            entry_q     <= entry_d;
        end
    end

    assign col       = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign entry     = entry_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: keypad matrix model, per-frame run-length
// reference model checked every cycle, directed scenarios plus random frames.
module tb_hex_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FL = 4 * SD;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] entry;
    logic [15:0] mask;

    hex_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB)) dut (
        .clk(clk), .reset(reset), .row(row), .clr(clr), .col(col),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .entry(entry)
    );

    always #5 clk = ~clk;

    // Physical keypad: pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[4*r+c] && !col[c]) row[r] = 1'b0;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses   = 0;
    int          last_pulse_t = -1;
    int          t;
    int          prev_cls;
    int          run;
    bit          m_held;
    bit          m_valid;
    logic [3:0]  m_code;
    logic [15:0] m_entry;

    // 0..15 = single key code, 16 = no key, 17 = several keys.
    function automatic int classify(input logic [15:0] m);
        int n = 0;
        int k = 0;
        for (int i = 0; i < 16; i++) if (m[i]) begin n++; k = i; end
        if (n == 0) return 16;
        if (n == 1) return k;
        return 17;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0; prev_cls = -1; run = 0; m_held = 0; m_valid = 0;
        m_code = 4'h0; m_entry = 16'h0000;
    endtask

    // Press accepted once DB identical single-key frames run while not held;
    // release once DB empty frames run while held.
    task automatic model_edge();
        int cls;
        bit acc;
        acc = 0;
        if (t % FL == FL - 1) begin
            cls = classify(mask);
            if (cls == prev_cls) run++;
            else begin run = 1; prev_cls = cls; end
            if (!m_held && cls < 16 && run == DB) begin
                acc = 1; m_held = 1; m_code = 4'(cls);
            end else if (m_held && cls == 16 && run == DB) begin
                m_held = 0;
            end
        end
        m_valid = acc;
        if (acc) m_entry = clr ? {12'h000, m_code} : {m_entry[11:0], m_code};
        else if (clr) m_entry = 16'h0000;
        t++;
    endtask

    task automatic compare_all();
        logic [3:0] one;
        one = 4'b0001;
        check("col", {12'h0, col}, {12'h0, ~(one << ((t / SD) % 4))});
        check("key_valid", {15'h0, key_valid}, {15'h0, m_valid});
        check("key_code", {12'h0, key_code}, {12'h0, m_code});
        check("key_held", {15'h0, key_held}, {15'h0, m_held});
        check("entry", entry, m_entry);
        if (key_valid === 1'b1) begin pulses++; last_pulse_t = t; end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_frame(input logic [15:0] m, input int clr_at);
        mask = m;
        for (int i = 0; i < FL; i++) begin
            clr = (i == clr_at);
            step();
        end
        clr = 1'b0;
    endtask

    task automatic frames(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) run_frame(m, -1);
    endtask

    initial begin
        logic [15:0] rm;
        int p0;
        reset = 1'b1; clr = 1'b0; mask = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Key (r2,c1) = code 9 held for 10 frames.
        p0 = pulses;
        frames(16'h0200, 10);
        check("t1_pulses", 16'(pulses - p0), 16'd1);
        check("t1_pulse_time", 16'(last_pulse_t), 16'd48);
        check("t1_code", {12'h0, key_code}, 16'h0009);
        check("t1_entry", entry, 16'h0009);
        check("t1_held", {15'h0, key_held}, 16'h0001);

        // Release, then codes 1, 2, 3, A each with a full release.
        frames(16'h0000, DB);
        p0 = pulses;
        frames(16'h0002, DB); frames(16'h0000, DB);
        frames(16'h0004, DB); frames(16'h0000, DB);
        frames(16'h0008, DB); frames(16'h0000, DB);
        frames(16'h0400, DB); frames(16'h0000, DB);
        check("t2_pulses", 16'(pulses - p0), 16'd4);
        check("t2_entry", entry, 16'h123A);
        run_frame(16'h0000, 5);
        check("t2_clr", entry, 16'h0000);

        // Bounce: on/off in two-frame bursts, never DB in a row.
        p0 = pulses;
        for (int i = 0; i < 8; i++) run_frame(((i / 2) % 2 == 0) ? 16'h0010 : 16'h0000, -1);
        frames(16'h0000, DB);
        check("t3_pulses", 16'(pulses - p0), 16'd0);
        check("t3_held", {15'h0, key_held}, 16'h0000);

        // Two keys from idle, then a second key added while held.
        p0 = pulses;
        frames(16'h0060, 10);
        check("t4_multi_pulses", 16'(pulses - p0), 16'd0);
        frames(16'h0020, DB);
        frames(16'h0060, 4);
        check("t4_held", {15'h0, key_held}, 16'h0001);
        check("t4_pulses", 16'(pulses - p0), 16'd1);
        frames(16'h0000, DB);

        // Release glitch shorter than the debounce window.
        p0 = pulses;
        frames(16'h0010, DB);
        frames(16'h0000, DB - 1);
        frames(16'h0010, 4);
        check("t5_held", {15'h0, key_held}, 16'h0001);
        check("t5_pulses", 16'(pulses - p0), 16'd1);
        frames(16'h0000, DB);

        // Reset in the middle of a debounce, key kept held.
        frames(16'h0080, DB - 1);
        repeat (5) step();
        reset = 1'b1;
        #1;
        model_reset();
        check("t6_col_rst", {12'h0, col}, 16'h000E);
        check("t6_entry_rst", entry, 16'h0000);
        check("t6_held_rst", {15'h0, key_held}, 16'h0000);
        check("t6_code_rst", {12'h0, key_code}, 16'h0000);
        repeat (2) step();
        reset = 1'b0;
        p0 = pulses;
        frames(16'h0080, DB);
        check("t6_reaccept_pulses", 16'(pulses - p0), 16'd1);
        check("t6_reaccept_time", 16'(last_pulse_t), 16'd48);
        check("t6_entry", entry, 16'h0007);
        frames(16'h0000, DB);
        frames(16'h1000, DB - 1);
        run_frame(16'h1000, FL - 1);
        check("t6_clr_accept", entry, 16'h000C);
        frames(16'h0000, DB);

        // Random frames: idle, repeat, single key or key pairs, sporadic clr.
        rm = 16'h0;
        for (int i = 0; i < 150; i++) begin
            int sel;
            int ca;
            sel = int'($urandom_range(0, 9));
            if (sel <= 2) rm = 16'h0;
            else if (sel >= 7 && sel <= 8) rm = 16'h1 << $urandom_range(0, 15);
            else if (sel == 9) rm = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            ca = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, FL - 1)) : -1;
            run_frame(rm, ca);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
